// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Periodic event scheduler. A prescaler divides clk into a base
//               tick. NCH programmable channels count base ticks. Each channel
//               raises a pending event on expiry. Pending events are issued
//               one at a time on a valid/ready port, with round-robin
//               arbitration between channels.
//
// Ports       : clk          system clock, rising edge
//               reset        synchronous active-high reset
//               cfg_we       period write strobe
//               cfg_addr     channel index of the write (>= NCH is ignored)
//               cfg_data     period in base ticks (0 = never expires)
//               ch_en        per-channel enable
//               tick         registered one-cycle base-tick pulse
//               evt_valid    event offered
//               evt_id       channel of the offered event
//               evt_ready    consumer accepts the offered event
//               overrun      sticky per-channel overrun flags
//               overrun_clr  clears all overrun flags
//
// Build macro : TICK_SCHED_OVERRUN_EN - when defined, sticky overrun
//               registers are built. When undefined, overrun reads 0 and
//               overrun_clr is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int PRESCALE = 24000000,
    parameter int PSW      = 32,
    parameter int NCH      = 4,
    parameter int PW       = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_addr,
    input  logic [PW-1:0]  cfg_data,
    input  logic [NCH-1:0] ch_en,
    output logic           tick,
    output logic           evt_valid,
    output logic [2:0]     evt_id,
    input  logic           evt_ready,
    output logic [NCH-1:0] overrun,
    input  logic           overrun_clr
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [PSW-1:0] c_pcnt_max = PSW'(PRESCALE - 1);
    localparam logic [PSW-1:0] c_pcnt_one = PSW'(1);
    localparam logic [PW-1:0]  c_per_one  = PW'(1);
    localparam logic [2:0]     c_last_rst = 3'(NCH - 1);

    // Arbiter states
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_OFFER = 1'b1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [PSW-1:0] r_pcnt;
    logic           r_tick;

    logic [0:0]     r_state;
    logic           r_evt_valid;
    logic [2:0]     r_evt_id;
    logic [2:0]     r_last;

    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] w_pend_nxt;
    logic [7:0]     w_pend8;

    logic           w_grant_vld;
    logic [2:0]     w_grant_id;
    logic [3:0]     w_sum;
    logic           w_take;

    assign tick      = r_tick;
    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;

    // ------------------------------------------------------------------
    // Prescaler: counts 0..PRESCALE-1 and pulses tick on the wrap edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else if (r_pcnt == c_pcnt_max) begin
            r_pcnt <= '0;
            r_tick <= 1'b1;
        end else begin
            r_pcnt <= r_pcnt + c_pcnt_one;
            r_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search over pending bits, starting at last+1.
    // The loop walks from the farthest candidate to the nearest one, so
    // the final assignment that sticks is the first set bit in search
    // order. No early exit is needed.
    // ------------------------------------------------------------------
    assign w_pend8 = 8'(r_pend);

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 3'd0;
        w_sum       = 4'd0;
        for (int k = NCH; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + 4'(k);
            if (w_sum >= 4'(NCH)) begin
                w_sum = w_sum - 4'(NCH);
            end
            if (w_pend8[w_sum[2:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_sum[2:0];
            end
        end
    end

    // A grant is issued only from IDLE. It clears the granted pend bit on
    // the same edge.
    assign w_take = (r_state == c_ST_IDLE) && w_grant_vld;

    // ------------------------------------------------------------------
    // Per-channel counters, pending bits and optional overrun flags
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [PW-1:0] r_cnt;
        logic [PW-1:0] r_per;
        logic          w_wr;
        logic          w_clr;
        logic          w_exp;

        assign w_wr  = cfg_we && (cfg_addr == 3'(i));
        assign w_clr = w_take && (w_grant_id == 3'(i));

        // A write on the same edge restarts the channel and suppresses
        // any expiry.
        assign w_exp = ch_en[i] && !w_wr && r_tick && (r_per != '0)
                       && (r_cnt == (r_per - c_per_one));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_per <= '0;
            end else if (!ch_en[i]) begin
                r_cnt <= '0;
            end else if (w_wr) begin
                r_per <= cfg_data;
                r_cnt <= '0;
            end else if (r_tick && (r_per != '0)) begin
                r_cnt <= w_exp ? '0 : (r_cnt + c_per_one);
            end
        end

        // Expiry wins over a grant clear on the same edge, so a new event
        // is never lost.
        assign w_pend_nxt[i] = !ch_en[i] ? 1'b0 :
                               w_exp     ? 1'b1 :
                               w_clr     ? 1'b0 :
                                           r_pend[i];

`ifdef TICK_SCHED_OVERRUN_EN
        logic r_ovr;
        logic w_ovr_set;

        // Coalescing only counts as an overrun when the bit is still pending
        // after this edge. A same-edge grant consumes the old event.
        assign w_ovr_set = w_exp && r_pend[i] && !w_clr;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_ovr <= 1'b0;
            end else if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (overrun_clr) begin
                r_ovr <= 1'b0;
            end
        end

        assign overrun[i] = r_ovr;
`else
        assign overrun[i] = 1'b0;
`endif
    end

`ifndef TICK_SCHED_OVERRUN_EN
    logic w_unused_ovr_clr;
    assign w_unused_ovr_clr = overrun_clr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM. IDLE always separates consecutive offers, so the port
    // issues at most one event every two cycles. An offer stays in place
    // even if its channel is disabled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_evt_valid <= 1'b0;
            r_evt_id    <= 3'd0;
            r_last      <= c_last_rst;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_evt_id    <= w_grant_id;
                        r_evt_valid <= 1'b1;
                        r_state     <= c_ST_OFFER;
                    end
                end
                c_ST_OFFER: begin
                    if (evt_ready) begin
                        r_evt_valid <= 1'b0;
                        r_last      <= r_evt_id;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Self-checking bench for tick_scheduler (PRESCALE=4, NCH=4,
//               PW=16). Directed scenarios push expected events (channel and
//               acceptance cycle) into a scoreboard. A monitor pops and
//               compares them on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int PRESCALE = 4;
    localparam int PSW      = 32;
    localparam int NCH      = 4;
    localparam int PW       = 16;

`ifdef TICK_SCHED_OVERRUN_EN
    localparam bit c_ovr_built = 1'b1;
`else
    localparam bit c_ovr_built = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [2:0]     cfg_addr;
    logic [PW-1:0]  cfg_data;
    logic [NCH-1:0] ch_en;
    logic           tick;
    logic           evt_valid;
    logic [2:0]     evt_id;
    logic           evt_ready;
    logic [NCH-1:0] overrun;
    logic           overrun_clr;

    tick_scheduler #(
        .PRESCALE (PRESCALE),
        .PSW      (PSW),
        .NCH      (NCH),
        .PW       (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .ch_en       (ch_en),
        .tick        (tick),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ready   (evt_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen with reset low ("cycle" numbering)
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [2:0] id;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input logic [2:0] id, input int c);
        exp_t e;
        e.id  = id;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: a handshake completes at the next rising edge
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_evt: got id %0d at cycle %0d, expected none", evt_id, cyc);
            end else begin
                m_e = sb.pop_front();
                check("evt_id", int'(evt_id), int'(m_e.id));
                check("evt_cycle", cyc, m_e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 1000) begin
            step(1);
            guard++;
        end
        if (cyc != c) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cycle: got %0d, expected %0d", cyc, c);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_addr    = 3'd0;
        cfg_data    = '0;
        ch_en       = '0;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        step(3);
        sb.delete();
    endtask

    task automatic sb_drained(input string name);
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        check("rst_tick", int'(tick), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_id", int'(evt_id), 0);
        check("rst_overrun", int'(overrun), 0);

        // S1: no channels enabled; tick every 4 cycles, no events
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            check("s1_tick", int'(tick), int'(k % 4 == 0));
            check("s1_valid", int'(evt_valid), 0);
        end

        // S2: per[0]=3; offers at 14, 26, 38
        apply_reset();
        ch_en     = 4'b0001;
        evt_ready = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_data  = 16'd3;
        expect_evt(3'd0, 14);
        expect_evt(3'd0, 26);
        expect_evt(3'd0, 38);
        reset = 1'b0;
        step(1);
        cfg_we = 1'b0;
        wait_until(45);
        sb_drained("s2_drained");

        // S3: per[0..2]=1, consumer stalled until cycle 20; round robin
        apply_reset();
        ch_en     = 4'b0111;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_data  = 16'd1;
        expect_evt(3'd0, 20);
        expect_evt(3'd1, 22);
        expect_evt(3'd2, 24);
        expect_evt(3'd0, 26);
        expect_evt(3'd1, 28);
        expect_evt(3'd2, 30);
        reset = 1'b0;
        step(1);
        cfg_addr = 3'd1;
        step(1);
        cfg_addr = 3'd2;
        step(1);
        cfg_we = 1'b0;
        wait_until(9);
        check("s3_ovr_c9", int'(overrun), c_ovr_built ? 6 : 0);
        wait_until(13);
        check("s3_ovr_c13", int'(overrun), c_ovr_built ? 7 : 0);
        wait_until(20);
        evt_ready = 1'b1;
        wait_until(31);
        evt_ready = 1'b0;
        ch_en     = 4'b0000;
        check("s3_ovr_c31", int'(overrun), c_ovr_built ? 7 : 0);
        step(1);
        check("s3_offer_valid", int'(evt_valid), 1);
        check("s3_offer_id", int'(evt_id), 0);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("s3_ovr_cleared", int'(overrun), 0);
        check("s3_offer_held", int'(evt_valid), 1);
        sb_drained("s3_drained");
        reset = 1'b1;
        step(1);
        check("s3_reset_drop", int'(evt_valid), 0);

        // S4: rewrite per[1]=2 on the tick edge while cnt[1]=1
        apply_reset();
        ch_en     = 4'b0010;
        evt_ready = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd1;
        cfg_data  = 16'd5;
        expect_evt(3'd1, 18);
        expect_evt(3'd1, 26);
        reset = 1'b0;
        step(1);
        cfg_we = 1'b0;
        wait_until(8);
        check("s4_tick_c8", int'(tick), 1);
        cfg_we   = 1'b1;
        cfg_addr = 3'd1;
        cfg_data = 16'd2;
        step(1);
        cfg_we = 1'b0;
        wait_until(28);
        sb_drained("s4_drained");

        // S5: pend[3] dropped by disable before grant, then re-enabled
        apply_reset();
        ch_en     = 4'b1001;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_data  = 16'd1;
        expect_evt(3'd0, 12);
        expect_evt(3'd0, 14);
        expect_evt(3'd0, 18);
        expect_evt(3'd3, 22);
        expect_evt(3'd0, 24);
        expect_evt(3'd0, 26);
        reset = 1'b0;
        step(1);
        cfg_addr = 3'd3;
        cfg_data = 16'd2;
        step(1);
        cfg_we = 1'b0;
        wait_until(10);
        ch_en = 4'b0001;
        wait_until(12);
        evt_ready = 1'b1;
        wait_until(14);
        ch_en = 4'b1001;
        wait_until(28);
        evt_ready = 1'b0;
        sb_drained("s5_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
# tick_scheduler

Periodic event scheduler built around the slow-tick prescaler. It divides `clk` into a base tick and runs NCH independently programmable channels on that tick. Channel expiries are queued as pending events and issued one at a time over a valid/ready port, with round-robin arbitration between channels. It sits between the system clock and any consumers of periodic events, such as display refresh, sampling or debounce logic.

## Interface
- PRESCALE, 24000000: `clk` cycles per base tick; must be ≥ 2.
- PSW, 32: prescaler counter width.
- NCH, 4: number of channels, 1..8.
- PW, 16: period register width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  period write strobe.
- cfg_addr  in  3  channel index; writes with index ≥ NCH are ignored.
- cfg_data  in  PW  period in base ticks; 0 means the channel never expires.
- ch_en  in  NCH  per-channel enable.
- tick  out  1  registered one-cycle base-tick pulse.
- evt_valid  out  1  an event is offered.
- evt_id  out  3  channel of the offered event.
- evt_ready  in  1  consumer accepts the event.
- overrun  out  NCH  sticky per-channel overrun flags.
- overrun_clr  in  1  clears all overrun flags.

## Operation
- Prescaler: `pcnt` counts 0..PRESCALE-1.
  - At an edge where `pcnt`==PRESCALE-1: `pcnt`<=0 and `tick`<=1.
  - At every other edge: `pcnt`+1 and `tick`<=0.
- Channel i, per `clk` edge, in priority order:
  1. `ch_en[i]`==0: `cnt[i]`<=0 and `pend[i]`<=0.
  2. cfg write to i: `per[i]`<=`cfg_data`, `cnt[i]`<=0, no expiry this edge.
  3. `tick` && `per[i]`!=0: if `cnt[i]`==`per[i]`-1, then `cnt[i]`<=0 and the channel expires; otherwise `cnt[i]`+1.
- Expiry:
  - Sets `pend[i]`.
  - If `pend[i]` is already 1, events coalesce: `pend` stays 1 and `overrun[i]` is set.
- Arbiter FSM, two states:
  - IDLE: if any `pend` bit is set, grant the first set bit searching from `last`+1 with wrap modulo NCH. On that edge: `evt_id`<=grant, `evt_valid`<=1, `pend[grant]`<=0, go to OFFER.
  - OFFER: `evt_valid` and `evt_id` are held stable. When `evt_ready`==1 at an edge: `evt_valid`<=0, `last`<=`evt_id`, go to IDLE.
- Simultaneous events:
  - Grant clear and expiry of the same channel on the same edge: `pend` ends at 1, no overrun.
  - Overrun set and `overrun_clr` on the same edge: the set wins.
  - Expiry of the channel currently being offered (its `pend` already cleared): `pend` is set normally, no overrun.
  - Disabling a channel while it is offered does not withdraw the offer.
- Arithmetic: `cnt` is PW bits wide. `per`=1 expires on every tick; `per`=2^PW-1 is the maximum period.

## Timing
- Reset values:
  - `tick`=0, `evt_valid`=0, `evt_id`=0, `overrun`=0.
  - `pcnt`=0, all `cnt`/`per`/`pend`=0.
  - `last`=NCH-1, so the first search starts at channel 0.
  - FSM in IDLE.
- Reset asserted mid-OFFER drops the event; no handshake completes.
- First `tick` is high in cycle PRESCALE after reset deassertion (cycle 1 = first edge with reset low), then every PRESCALE cycles.
- Latency: `tick` high in cycle t → `pend` visible in t+1 → `evt_valid` high in t+2 if the FSM is idle.
- Throughput: at most one event per 2 cycles, because IDLE always separates consecutive offers.
- A cfg write takes effect at the same edge; the next expiry comes exactly `per` ticks later.

## Configuration
- `TICK_SCHED_OVERRUN_EN` defined: sticky overrun registers are built and behave as described above.
- `TICK_SCHED_OVERRUN_EN` undefined:
  - No overrun registers are built.
  - `overrun` is tied to 0 and `overrun_clr` is ignored.
  - Coalescing of expiries into a set `pend` bit is unchanged.

## Test plan
All scenarios use PRESCALE=4, NCH=4, PW=16.
- Reset, `ch_en`=0 → `tick` high in cycles 4, 8, 12; `evt_valid` stays 0 for 50 cycles.
- `per[0]`=3, `ch_en`=0001, `evt_ready`=1 → `evt_id`=0 offered every 12 cycles, `evt_valid` rising 2 cycles after every third `tick`.
- `per[0..2]`=1, `ch_en`=0111, `evt_ready`=0 for 20 cycles then 1 → grants in order 0,1,2,0,1,2; `overrun`=0111; after an `overrun_clr` pulse, `overrun`=0000.
- cfg write `per[1]`=2 in the same cycle as `tick` while `cnt[1]`=1 → no expiry on that tick; next expiry after 2 further ticks.
- `pend[3]` set, then `ch_en[3]` dropped before the grant → no event for channel 3; re-enabling restarts from `cnt`=0.
- Build without `TICK_SCHED_OVERRUN_EN`, repeat the round-robin scenario → same grant order, `overrun` always 0000.
